// File: rtl/bch_syndrome_check_if.sv
// Handshake and result bundle between the codeword source and the syndrome checker.
// The master drives start/codeword_in; the checker (slave) returns status and results.
interface bch_syndrome_check_if #(
  parameter int N = 64,
  parameter int K = 40
);
  logic             start;
  logic [N-1:0]     codeword_in;
  logic             busy;
  logic             done;
  logic [N-K-1:0]   syndrome;
  logic             error;
  logic [K-1:0]     data_out;

  modport master (
    output start, codeword_in,
    input  busy, done, syndrome, error, data_out
  );

  modport slave (
    input  start, codeword_in,
    output busy, done, syndrome, error, data_out
  );
endinterface

// File: rtl/bch_syndrome_check.sv
// Receive-side checker: shifts a latched 64-bit codeword MSB-first through the
// 24-bit generator LFSR and reports syndrome, error flag and the data field.
//
// state | meaning
// IDLE  | waiting for start; results from the last check are held
// SHIFT | one codeword bit per clock through the LFSR, cnt = 0..N-1
// DONE  | one-cycle result strobe; start here re-arms immediately
module bch_syndrome_check #(
  parameter int N = 64,
  parameter int K = 40
) (
  input logic              clk,
  input logic              rst,
  bch_syndrome_check_if.slave bus
);

  // The tap positions below are fixed for the 24-bit generator, so N-K must be 24.
  localparam int P  = N - K;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [P-1:0]   r;
  logic [P-1:0]   r_next;
  logic [N-1:0]   shadow;
  logic [K-1:0]   data_hold;
  logic           fb;

  always_comb begin
    fb        = shadow[N-1] ^ r[0];
    r_next    = {fb, r[P-1:1]};
    r_next[4]  = r[5]  ^ fb;
    r_next[8]  = r[9]  ^ fb;
    r_next[14] = r[15] ^ fb;
    r_next[19] = r[20] ^ fb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      r            <= '0;
      shadow       <= '0;
      data_hold    <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.syndrome <= '0;
      bus.error    <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= SHIFT;
            shadow    <= bus.codeword_in;
            data_hold <= bus.codeword_in[N-1:N-K];
            r         <= '0;
            cnt       <= '0;
            bus.busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // shadow moves left so the bit under test is always its MSB
          shadow <= shadow << 1;
          r      <= r_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.syndrome <= r_next;
            bus.error    <= |r_next;
            bus.data_out <= data_hold;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
